// File: rtl/stream_maxpool2x2.sv
// Streaming 2x2 / stride-2 signed max-pool stage for the conv core output stream.
// Row maxima of even rows are parked in a half-width line buffer and combined on odd rows.
module stream_maxpool2x2 #(
    parameter int MAX_W = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] Cext,
    input  logic [7:0]  Hext,
    input  logic [7:0]  Wext,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [15:0] din_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [15:0] dout_data,
    output logic        busy,
    output logic        done
);

    localparam int LB_DEPTH = MAX_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] c_q, c_d;
    logic [7:0]  h_q, h_d;
    logic [7:0]  w_q, w_d;
    logic [7:0]  col_q, col_d;
    logic [7:0]  row_q, row_d;
    logic [10:0] ch_q, ch_d;
    logic [15:0] hreg_q, hreg_d;
    logic        dout_valid_q, dout_valid_d;
    logic [15:0] dout_data_q, dout_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0]      linebuf_q [LB_DEPTH];
    logic             lb_we;
    logic [LB_AW-1:0] lb_addr;
    logic [15:0]      lb_wdata;
    logic [15:0]      lb_rdata;

    logic        in_xfer;
    logic        out_xfer;
    logic        in_region;
    logic        pool_load;
    logic        last_col;
    logic        last_row;
    logic        last_ch;
    logic [7:0]  h_even;
    logic [7:0]  w_even;
    logic [15:0] pair_max;
    logic [15:0] pooled;

    function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    assign din_ready  = (state_q == S_RUN) && (!dout_valid_q || dout_ready);
    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

    assign lb_addr  = LB_AW'(col_q >> 1);
    assign lb_rdata = linebuf_q[lb_addr];

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        h_d          = h_q;
        w_d          = w_q;
        col_d        = col_q;
        row_d        = row_q;
        ch_d         = ch_q;
        hreg_d       = hreg_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;

        in_xfer   = din_valid && din_ready;
        out_xfer  = dout_valid_q && dout_ready;
        h_even    = {h_q[7:1], 1'b0};
        w_even    = {w_q[7:1], 1'b0};
        in_region = (row_q < h_even) && (col_q < w_even);
        last_col  = (col_q == w_q - 8'd1);
        last_row  = (row_q == h_q - 8'd1);
        last_ch   = (ch_q == c_q - 11'd1);
        pair_max  = smax(hreg_q, din_data);
        pooled    = smax(lb_rdata, pair_max);
        pool_load = in_xfer && in_region && col_q[0] && row_q[0];
        lb_we     = in_xfer && in_region && col_q[0] && !row_q[0];
        lb_wdata  = pair_max;

        if (in_xfer && in_region && !col_q[0]) begin
            hreg_d = din_data;
        end

        // An output transfer and a new pooled value in the same cycle simply reload the register.
        if (out_xfer) begin
            dout_valid_d = 1'b0;
        end
        if (pool_load) begin
            dout_valid_d = 1'b1;
            dout_data_d  = pooled;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    c_d     = Cext;
                    h_d     = Hext;
                    w_d     = Wext;
                    col_d   = 8'd0;
                    row_d   = 8'd0;
                    ch_d    = 11'd0;
                end
            end
            S_RUN: begin
                if (in_xfer) begin
                    if (last_col) begin
                        col_d = 8'd0;
                        if (last_row) begin
                            row_d = 8'd0;
                            ch_d  = ch_q + 11'd1;
                        end else begin
                            row_d = row_q + 8'd1;
                        end
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                    if (last_ch && last_row && last_col) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!dout_valid_q || out_xfer) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            c_q          <= 11'd0;
            h_q          <= 8'd0;
            w_q          <= 8'd0;
            col_q        <= 8'd0;
            row_q        <= 8'd0;
            ch_q         <= 11'd0;
            hreg_q       <= 16'd0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= 16'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            h_q          <= h_d;
            w_q          <= w_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ch_q         <= ch_d;
            hreg_q       <= hreg_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Contents need no reset: every entry is written on an even row before an odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_addr] <= lb_wdata;
        end
    end

endmodule
